// File: rtl/cnt_iter_pkg.sv
// Shared definitions for the iterative bit-count engine: operation encodings and FSM states.
package cnt_iter_pkg;

  localparam logic [1:0] CNT_CLZ  = 2'b00;
  localparam logic [1:0] CNT_CTZ  = 2'b01;
  localparam logic [1:0] CNT_CPOP = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/cnt_iter_if.sv
// Request/response bundle between operand select, the count engine and the result mux.
interface cnt_iter_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Flush;
  logic [1:0]       Op;
  logic             W64;
  logic [WIDTH-1:0] A;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] CntResult;

  modport master (
    output Start, Flush, Op, W64, A,
    input  Busy, Done, CntResult
  );

  modport slave (
    input  Start, Flush, Op, W64, A,
    output Busy, Done, CntResult
  );
endinterface

// File: rtl/cnt_iter_chunk.sv
// Combinational per-chunk counter: all-zero flag, leading-zero count and population count.
module cnt_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]         i_chunk,
  output logic                     o_zero,
  output logic [$clog2(CHUNK):0]   o_lzc,
  output logic [$clog2(CHUNK):0]   o_pop
);
  localparam int LW = $clog2(CHUNK) + 1;

  assign o_zero = ~|i_chunk;

  // Scanning upward lets the highest set bit overwrite the leading-zero count last.
  always_comb begin
    o_pop = '0;
    o_lzc = LW'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      o_pop = o_pop + LW'(i_chunk[i]);
      if (i_chunk[i]) begin
        o_lzc = LW'(CHUNK - 1 - i);
      end
    end
  end

endmodule

// File: rtl/cnt_iter.sv
// Multi-cycle clz/ctz/cpop engine: examines CHUNK bits per cycle from the top of a shift register.
module cnt_iter
  import cnt_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic      clk,
  input  logic      reset,
  cnt_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int LW = $clog2(CHUNK) + 1;
  localparam int RW = $clog2(WIDTH / CHUNK) + 1;

  cnt_state_t       r_state;
  logic [WIDTH-1:0] r_S;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_C;
  logic [RW-1:0]    r_R;
  logic             r_found;
  logic             r_isCpop;
  logic             r_busy;
  logic             r_done;

  logic [CHUNK-1:0] w_K;
  logic             w_zero;
  logic [LW-1:0]    w_lzc;
  logic [LW-1:0]    w_pop;
  logic [CW-1:0]    w_add;
  logic [CW-1:0]    w_cNext;
  logic [WIDTH-1:0] w_sNext;
  logic [WIDTH-1:0] w_revFull;
  logic [WIDTH-1:0] w_loadFull;
  logic [WIDTH-1:0] w_loadWord;
  logic [WIDTH-1:0] w_load;
  logic [31:0]      w_loRev;
  logic [31:0]      w_loSel;
  logic [RW-1:0]    w_rNext;
  logic [RW-1:0]    w_rLoad;
  logic             w_isCtz;
  logic             w_useWord;
  logic             w_foundNow;
  logic             w_finish;

  always_comb begin
    w_revFull = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_revFull[i] = bus.A[WIDTH-1-i];
    end
    w_loRev = '0;
    for (int i = 0; i < 32; i++) begin
      w_loRev[i] = bus.A[31-i];
    end
  end

  // Word ops left-justify the low 32 bits so the scan always starts at the MSB.
  assign w_isCtz    = (bus.Op == CNT_CTZ);
  assign w_useWord  = (WIDTH == 64) ? bus.W64 : 1'b0;
  assign w_loadFull = w_isCtz ? w_revFull : bus.A;
  assign w_loSel    = w_isCtz ? w_loRev : bus.A[31:0];
  assign w_loadWord = WIDTH'(w_loSel) << (WIDTH - 32);
  assign w_load     = w_useWord ? w_loadWord : w_loadFull;
  assign w_rLoad    = w_useWord ? RW'(32 / CHUNK) : RW'(WIDTH / CHUNK);

  assign w_K = r_S[WIDTH-1 -: CHUNK];

  cnt_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .i_chunk (w_K),
    .o_zero  (w_zero),
    .o_lzc   (w_lzc),
    .o_pop   (w_pop)
  );

  assign w_add      = r_isCpop ? CW'(w_pop) : (w_zero ? CW'(CHUNK) : CW'(w_lzc));
  assign w_cNext    = r_C + w_add;
  assign w_sNext    = r_S << CHUNK;
  assign w_rNext    = r_R - 1'b1;
  assign w_foundNow = !r_isCpop && !w_zero;

  // cpop can stop as soon as no set bits remain below the examined chunk.
  assign w_finish = (!r_isCpop && (w_foundNow || r_found)) ||
                    (r_isCpop && (w_sNext == '0)) ||
                    (w_rNext == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_S      <= '0;
      r_result <= '0;
      r_C      <= '0;
      r_R      <= '0;
      r_found  <= 1'b0;
      r_isCpop <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (bus.Flush) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.Start) begin
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_S      <= w_load;
            r_C      <= '0;
            r_R      <= w_rLoad;
            r_found  <= 1'b0;
            r_isCpop <= bus.Op[1];
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_S     <= w_sNext;
          r_R     <= w_rNext;
          r_C     <= w_cNext;
          r_found <= r_found | w_foundNow;
          if (w_finish) begin
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= WIDTH'(w_cNext);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.CntResult = r_result;

endmodule

// File: tb/tb_cnt_iter.sv
// Directed bench for cnt_iter: a 32-bit and a 64-bit instance driven from one vector table.
module tb_cnt_iter;
  import cnt_iter_pkg::*;

  typedef struct {
    bit          use64;
    logic [1:0]  op;
    bit          w64;
    logic [63:0] a;
    logic [63:0] expRes;
    int          chunks;
  } vec_t;

  logic clk;
  logic reset;
  int   nApplied;
  int   nFail;
  vec_t vecs [14];

  cnt_iter_if #(.WIDTH(32)) if32 ();
  cnt_iter_if #(.WIDTH(64)) if64 ();

  cnt_iter #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (if32.slave)
  );

  cnt_iter #(.WIDTH(64), .CHUNK(8)) dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (if64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic getBusy(input bit use64);
    return use64 ? if64.Busy : if32.Busy;
  endfunction

  function automatic logic getDone(input bit use64);
    return use64 ? if64.Done : if32.Done;
  endfunction

  function automatic logic [63:0] getResult(input bit use64);
    return use64 ? if64.CntResult : {32'h0, if32.CntResult};
  endfunction

  task automatic setInputs(input bit use64, input bit start, input bit flush,
                           input logic [1:0] op, input bit w64, input logic [63:0] a);
    if32.Start = start && !use64;
    if32.Flush = flush && !use64;
    if32.Op    = op;
    if32.W64   = w64;
    if32.A     = a[31:0];
    if64.Start = start && use64;
    if64.Flush = flush && use64;
    if64.Op    = op;
    if64.W64   = w64;
    if64.A     = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nApplied++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Start one operation, count cycles until Done, and check latency, Busy and result.
  task automatic applyStimulus(input int idx, input vec_t v);
    int cyc;
    bit busyOk;
    tick();
    setInputs(v.use64, 1'b1, 1'b0, v.op, v.w64, v.a);
    tick();
    setInputs(v.use64, 1'b0, 1'b0, v.op, v.w64, v.a);
    cyc = 1;
    busyOk = 1'b1;
    while (!getDone(v.use64) && cyc <= 20) begin
      if (!getBusy(v.use64)) busyOk = 1'b0;
      tick();
      cyc++;
    end
    checkOutput($sformatf("vec%0d_latency", idx), 64'(cyc), 64'(v.chunks + 1));
    checkOutput($sformatf("vec%0d_busyDuringRun", idx), 64'(busyOk), 64'd1);
    checkOutput($sformatf("vec%0d_busyAtDone", idx), 64'(getBusy(v.use64)), 64'd0);
    checkOutput($sformatf("vec%0d_result", idx), getResult(v.use64), v.expRes);
    tick();
    checkOutput($sformatf("vec%0d_donePulse", idx), 64'(getDone(v.use64)), 64'd0);
  endtask

  initial begin
    int  cyc;
    bit  sawDone;

    nApplied = 0;
    nFail    = 0;

    vecs[0]  = '{1'b0, CNT_CLZ,  1'b0, 64'h0000_0000_0001_0000, 64'd15, 2};
    vecs[1]  = '{1'b0, CNT_CTZ,  1'b0, 64'h0000_0000_8000_0000, 64'd31, 4};
    vecs[2]  = '{1'b0, CNT_CLZ,  1'b0, 64'h0,                   64'd32, 4};
    vecs[3]  = '{1'b0, CNT_CPOP, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd32, 4};
    vecs[4]  = '{1'b0, CNT_CPOP, 1'b0, 64'h0000_0000_F000_0000, 64'd4,  1};
    vecs[5]  = '{1'b0, 2'b11,    1'b0, 64'h0000_0000_0000_0101, 64'd2,  4};
    vecs[6]  = '{1'b0, CNT_CTZ,  1'b0, 64'h0,                   64'd32, 4};
    vecs[7]  = '{1'b1, CNT_CLZ,  1'b1, 64'hFFFF_FFFF_0000_0001, 64'd31, 4};
    vecs[8]  = '{1'b1, CNT_CLZ,  1'b0, 64'hFFFF_FFFF_0000_0001, 64'd0,  1};
    vecs[9]  = '{1'b1, CNT_CPOP, 1'b1, 64'hFFFF_FFFF_0000_000F, 64'd4,  4};
    vecs[10] = '{1'b1, CNT_CTZ,  1'b0, 64'h0000_0000_0000_0100, 64'd8,  2};
    vecs[11] = '{1'b1, CNT_CPOP, 1'b0, 64'h0,                   64'd0,  1};
    vecs[12] = '{1'b1, CNT_CTZ,  1'b1, 64'h1234_5678_0000_0010, 64'd4,  1};
    vecs[13] = '{1'b1, CNT_CLZ,  1'b0, 64'h0,                   64'd64, 8};

    reset = 1'b0;
    setInputs(1'b0, 1'b0, 1'b0, CNT_CLZ, 1'b0, 64'h0);
    tick();
    tick();
    checkOutput("reset_busy32",   64'(if32.Busy), 64'd0);
    checkOutput("reset_done32",   64'(if32.Done), 64'd0);
    checkOutput("reset_result32", getResult(1'b0), 64'd0);
    checkOutput("reset_busy64",   64'(if64.Busy), 64'd0);
    checkOutput("reset_done64",   64'(if64.Done), 64'd0);
    checkOutput("reset_result64", getResult(1'b1), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Flush mid-run: no Done, previous result (32 from the ctz of zero) retained.
    tick();
    setInputs(1'b0, 1'b1, 1'b0, CNT_CLZ, 1'b0, 64'h0);
    tick();
    setInputs(1'b0, 1'b0, 1'b0, CNT_CLZ, 1'b0, 64'h0);
    checkOutput("flush_busyBefore", 64'(if32.Busy), 64'd1);
    tick();
    setInputs(1'b0, 1'b0, 1'b1, CNT_CLZ, 1'b0, 64'h0);
    tick();
    setInputs(1'b0, 1'b0, 1'b0, CNT_CLZ, 1'b0, 64'h0);
    checkOutput("flush_busyAfter", 64'(if32.Busy), 64'd0);
    checkOutput("flush_resultKept", getResult(1'b0), 64'd32);
    sawDone = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (if32.Done) sawDone = 1'b1;
      tick();
    end
    checkOutput("flush_noDone", 64'(sawDone), 64'd0);

    // Start and Flush together while idle: request dropped.
    setInputs(1'b0, 1'b1, 1'b1, CNT_CPOP, 1'b0, 64'h1);
    tick();
    setInputs(1'b0, 1'b0, 1'b0, CNT_CLZ, 1'b0, 64'h0);
    checkOutput("startFlush_busy", 64'(if32.Busy), 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (if32.Done) sawDone = 1'b1;
      tick();
    end
    checkOutput("startFlush_noDone", 64'(sawDone), 64'd0);
    checkOutput("startFlush_result", getResult(1'b0), 64'd32);

    // Back-to-back: second Start issued during the DONE cycle of a cpop.
    setInputs(1'b0, 1'b1, 1'b0, CNT_CPOP, 1'b0, 64'h0000_00FF);
    tick();
    setInputs(1'b0, 1'b0, 1'b0, CNT_CLZ, 1'b0, 64'h0);
    cyc = 1;
    while (!if32.Done && cyc <= 20) begin
      tick();
      cyc++;
    end
    checkOutput("b2b_firstLatency", 64'(cyc), 64'd5);
    checkOutput("b2b_firstResult", getResult(1'b0), 64'd8);
    setInputs(1'b0, 1'b1, 1'b0, CNT_CLZ, 1'b0, 64'h0F00_0000);
    tick();
    setInputs(1'b0, 1'b0, 1'b0, CNT_CLZ, 1'b0, 64'h0);
    checkOutput("b2b_secondBusy", 64'(if32.Busy), 64'd1);
    checkOutput("b2b_secondDoneEarly", 64'(if32.Done), 64'd0);
    tick();
    checkOutput("b2b_secondDone", 64'(if32.Done), 64'd1);
    checkOutput("b2b_secondResult", getResult(1'b0), 64'd4);

    // Reset during RUN clears everything at the next edge.
    tick();
    setInputs(1'b0, 1'b1, 1'b0, CNT_CLZ, 1'b0, 64'h0);
    tick();
    setInputs(1'b0, 1'b0, 1'b0, CNT_CLZ, 1'b0, 64'h0);
    checkOutput("runReset_busyBefore", 64'(if32.Busy), 64'd1);
    reset = 1'b0;
    tick();
    checkOutput("runReset_busy",     64'(if32.Busy), 64'd0);
    checkOutput("runReset_done",     64'(if32.Done), 64'd0);
    checkOutput("runReset_result",   getResult(1'b0), 64'd0);
    checkOutput("runReset_result64", getResult(1'b1), 64'd0);
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
    $finish;
  end

endmodule
